// File: rtl/mips_mem_pkg.sv
// Shared types and width helpers for the unified instruction/data memory port arbiter.
package mips_mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} arb_state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  // Starve counter width; covers STARVE_MAX up to 15.
  localparam int STV_W = 4;

  // Latency counter width: clog2(RD_LATENCY+1), never below one bit.
  function automatic int lat_w(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/arb_fair_pick.sv
// Winner select between fetch and data requesters; data has priority unless
// fetch has been passed over STARVE_MAX consecutive times.
module arb_fair_pick
  import mips_mem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic dm_req,
  input  logic issue,
  output logic pick_if
);

  localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_MAX);

  logic [STV_W-1:0] starve_reg;

  assign pick_if = if_req && (!dm_req || (starve_reg == STV_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_reg <= '0;
    end else if (issue) begin
      // Only a data grant that bypasses a waiting fetch counts as starvation.
      if (pick_if || !if_req) begin
        starve_reg <= '0;
      end else if (starve_reg != STV_MAX) begin
        starve_reg <= starve_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and data
// requesters with a req/gnt/rvalid handshake and one access outstanding.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RD_LATENCY = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_cen,
  output logic          mem_wen,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  input  logic [DW-1:0] mem_q
);

  localparam int LW = lat_w(RD_LATENCY);
  localparam logic [LW-1:0] LAT_LAST = LW'(RD_LATENCY - 1);

  arb_state_t    state_reg, state_next;
  owner_t        owner_reg;
  logic          we_reg;
  logic [LW-1:0] lat_reg;
  logic [DW-1:0] if_rdata_reg, dm_rdata_reg;
  logic [AW-1:0] a_reg;
  logic [DW-1:0] d_reg;
  logic          issue;
  logic          pick_if;
  logic          lat_done;

  // Gated by rst so that grants and the memory enable fall immediately on reset.
  assign issue    = !rst && (state_reg != WAIT) && (if_req || dm_req);
  assign lat_done = (state_reg == WAIT) && (lat_reg == LAT_LAST);
  assign if_rdata = if_rdata_reg;
  assign dm_rdata = dm_rdata_reg;

  arb_fair_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk    (clk),
    .rst    (rst),
    .if_req (if_req),
    .dm_req (dm_req),
    .issue  (issue),
    .pick_if(pick_if)
  );

  always_comb begin
    state_next = state_reg;
    if_gnt     = 1'b0;
    dm_gnt     = 1'b0;
    if_rvalid  = 1'b0;
    dm_rvalid  = 1'b0;
    mem_cen    = 1'b0;
    mem_wen    = 1'b0;
    mem_a      = a_reg;
    mem_d      = d_reg;

    case (state_reg)
      WAIT: begin
        if (lat_done) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if_rvalid  = (owner_reg == OWN_IF);
        dm_rvalid  = (owner_reg == OWN_DM);
        state_next = IDLE;
      end
      default: state_next = state_reg;
    endcase

    // Issue overrides RESP's return to IDLE, giving back-to-back accesses.
    if (issue) begin
      state_next = WAIT;
      mem_cen    = 1'b1;
      if (pick_if) begin
        if_gnt = 1'b1;
        mem_a  = if_addr;
      end else begin
        dm_gnt  = 1'b1;
        mem_a   = dm_addr;
        mem_wen = dm_we;
        mem_d   = dm_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      owner_reg    <= OWN_IF;
      we_reg       <= 1'b0;
      lat_reg      <= '0;
      if_rdata_reg <= '0;
      dm_rdata_reg <= '0;
      a_reg        <= '0;
      d_reg        <= '0;
    end else begin
      state_reg <= state_next;
      if (issue) begin
        owner_reg <= pick_if ? OWN_IF : OWN_DM;
        we_reg    <= !pick_if && dm_we;
        lat_reg   <= '0;
        a_reg     <= mem_a;
        d_reg     <= mem_d;
      end else if (state_reg == WAIT) begin
        lat_reg <= lat_reg + 1'b1;
      end
      if (lat_done) begin
        if (owner_reg == OWN_IF) begin
          if_rdata_reg <= mem_q;
        end else begin
          dm_rdata_reg <= we_reg ? '0 : mem_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized checks of mem_port_arbiter against a transaction-level
// reference model and a behavioural single-port memory with configurable latency.
module tb_mem_port_arbiter;

  localparam int L  = 2;
  localparam int SM = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_cen, mem_wen;
  logic [31:0] mem_a, mem_d, mem_q;

  mem_port_arbiter #(
    .AW(32), .DW(32), .RD_LATENCY(L), .STARVE_MAX(SM)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_a(mem_a), .mem_d(mem_d),
    .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // Behavioural memory macro: read data appears L cycles after the enable edge.
  logic [31:0] mem_arr [256];
  logic [31:0] pipe [L];
  always @(posedge clk) begin
    if (mem_cen && mem_wen) mem_arr[mem_a[9:2]] <= mem_d;
    pipe[0] <= (mem_cen && !mem_wen) ? mem_arr[mem_a[9:2]] : 32'hBAD0_BAD0;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_q = pipe[L-1];

  // Reference model state.
  logic [31:0] ref_mem [256];
  int          cyc, next_ok, resp_cyc, starve;
  logic        resp_if;
  logic [31:0] resp_data, m_if_rd, m_dm_rd;
  logic        last_ig, last_dg, if_hold, dm_hold;
  logic        trace_on;
  logic        trace_q [$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_gnt"}, {31'b0, if_gnt}, 32'd0);
    chk({tag, "_dm_gnt"}, {31'b0, dm_gnt}, 32'd0);
    chk({tag, "_if_rvalid"}, {31'b0, if_rvalid}, 32'd0);
    chk({tag, "_dm_rvalid"}, {31'b0, dm_rvalid}, 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_dm_rdata"}, dm_rdata, 32'd0);
    chk({tag, "_mem_cen"}, {31'b0, mem_cen}, 32'd0);
    chk({tag, "_mem_wen"}, {31'b0, mem_wen}, 32'd0);
    chk({tag, "_mem_a"}, mem_a, 32'd0);
    chk({tag, "_mem_d"}, mem_d, 32'd0);
  endtask

  task automatic model_reset();
    cyc = 0; next_ok = 0; resp_cyc = -1; starve = 0;
    resp_if = 1'b0; resp_data = '0; m_if_rd = '0; m_dm_rd = '0;
  endtask

  // One clock cycle: inputs already driven; compare at the falling edge.
  task automatic step();
    logic exp_ig, exp_dg, exp_ir, exp_dr, win_if;
    @(negedge clk);
    exp_ig = 1'b0;
    exp_dg = 1'b0;
    exp_ir = (cyc == resp_cyc) && resp_if;
    exp_dr = (cyc == resp_cyc) && !resp_if;
    if (exp_ir) m_if_rd = resp_data;
    if (exp_dr) m_dm_rd = resp_data;
    if (cyc >= next_ok && (if_req || dm_req)) begin
      win_if = if_req && (!dm_req || starve == SM);
      if (win_if || !if_req) starve = 0;
      else if (starve < SM) starve = starve + 1;
      exp_ig = win_if;
      exp_dg = !win_if;
      resp_cyc = cyc + L + 1;
      next_ok  = cyc + L + 1;
      resp_if  = win_if;
      if (win_if) begin
        resp_data = ref_mem[if_addr[9:2]];
        chk("mem_a_if", mem_a, if_addr);
      end else begin
        chk("mem_a_dm", mem_a, dm_addr);
        if (dm_we) begin
          resp_data = '0;
          ref_mem[dm_addr[9:2]] = dm_wdata;
          chk("mem_d", mem_d, dm_wdata);
        end else begin
          resp_data = ref_mem[dm_addr[9:2]];
        end
      end
    end
    chk("if_gnt", {31'b0, if_gnt}, {31'b0, exp_ig});
    chk("dm_gnt", {31'b0, dm_gnt}, {31'b0, exp_dg});
    chk("if_rvalid", {31'b0, if_rvalid}, {31'b0, exp_ir});
    chk("dm_rvalid", {31'b0, dm_rvalid}, {31'b0, exp_dr});
    chk("if_rdata", if_rdata, m_if_rd);
    chk("dm_rdata", dm_rdata, m_dm_rd);
    chk("mem_cen", {31'b0, mem_cen}, {31'b0, exp_ig | exp_dg});
    chk("mem_wen", {31'b0, mem_wen}, {31'b0, exp_dg & dm_we});
    if (trace_on && (if_gnt || dm_gnt)) trace_q.push_back(if_gnt);
    last_ig = exp_ig;
    last_dg = exp_dg;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_drive();
    if (!if_hold) begin
      if_req  = ($urandom % 4) != 0;
      if_addr = {22'd0, 8'($urandom), 2'b00};
    end
    if (!dm_hold) begin
      dm_req   = ($urandom % 3) != 0;
      dm_we    = $urandom % 2;
      dm_addr  = {22'd0, 8'($urandom), 2'b00};
      dm_wdata = $urandom;
    end
  endtask

  initial begin
    logic exp_order [6];
    exp_order = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[8'h04] = 32'h2402000A; ref_mem[8'h04] = 32'h2402000A;
    mem_arr[8'h05] = 32'h8C220004; ref_mem[8'h05] = 32'h8C220004;
    mem_arr[8'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
    trace_on = 1'b0;
    if_hold = 1'b0; dm_hold = 1'b0;
    last_ig = 1'b0; last_dg = 1'b0;

    // Reset with requests present: everything must stay quiet.
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h10;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h1234_5678;
    #3;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    rst = 1'b0;
    model_reset();

    // Lone fetch from 0x10.
    if_req = 1'b1; if_addr = 32'h10;
    step();
    if_req = 1'b0;
    repeat (L + 1) step();
    chk("t1_if_rdata", if_rdata, 32'h2402000A);

    // Simultaneous requests: data first, fetch granted in the RESP cycle.
    if_req = 1'b1; if_addr = 32'h14;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
    step();
    dm_req = 1'b0;
    repeat (L) step();
    step();
    if_req = 1'b0;
    repeat (L + 1) step();
    chk("t2_dm_rdata", dm_rdata, 32'hDEADBEEF);
    chk("t2_if_rdata", if_rdata, 32'h8C220004);

    // Continuous contention: fairness order.
    trace_q.delete();
    trace_on = 1'b1;
    if_req = 1'b1; if_addr = 32'h18;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44;
    repeat (6 * (L + 1)) step();
    trace_on = 1'b0;
    if_req = 1'b0; dm_req = 1'b0;
    repeat (L + 1) step();
    chk("t3_grant_count", trace_q.size(), 32'd6);
    for (int i = 0; i < 6 && i < trace_q.size(); i++)
      chk($sformatf("t3_order_%0d", i), {31'b0, trace_q[i]}, {31'b0, exp_order[i]});

    // Write then read back-to-back.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h55AA55AA;
    step();
    dm_we = 1'b0; dm_wdata = 32'h0;
    repeat (L) step();
    step();
    dm_req = 1'b0;
    repeat (L + 1) step();
    chk("t4_dm_rdata", dm_rdata, 32'h55AA55AA);

    // Asynchronous reset in the last WAIT cycle; fetch re-presented afterwards.
    if_req = 1'b1; if_addr = 32'h10;
    step();
    repeat (L - 1) step();
    rst = 1'b1;
    #1;
    chk_all_zero("t5_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step();
    chk("t5_regrant", {31'b0, last_ig}, 32'd1);
    if_req = 1'b0;
    repeat (L + 1) step();

    // Continuous fetch: one grant per L+1 cycles, rvalid alongside the next grant.
    trace_q.delete();
    trace_on = 1'b1;
    if_req = 1'b1; if_addr = 32'h20;
    repeat (3 * (L + 1)) step();
    trace_on = 1'b0;
    if_req = 1'b0;
    repeat (L + 1) step();
    chk("t6_grant_count", trace_q.size(), 32'd3);

    // Randomized traffic obeying hold-until-grant.
    for (int n = 0; n < 600; n++) begin
      rand_drive();
      step();
      if_hold = if_req && !last_ig;
      dm_hold = dm_req && !last_dg;
    end
    if_req = 1'b0; dm_req = 1'b0;
    repeat (L + 2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
